// File: rtl/ap_txn_profiler_if.sv
// ap_ctrl handshake of one monitored module plus the valid/ready stream of
// per-transaction timing records produced by the profiler.
interface ap_txn_profiler_if #(
  parameter int CNT_W = 32,
  parameter int ID_W  = 16
);
  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_continue;
  logic             finish;
  logic             rec_valid;
  logic             rec_ready;
  logic [ID_W-1:0]  rec_id;
  logic [CNT_W-1:0] rec_start;
  logic [CNT_W-1:0] rec_end;
  logic [CNT_W-1:0] rec_latency;

  modport master (
    output ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready,
    input  rec_valid, rec_id, rec_start, rec_end, rec_latency
  );

  modport slave (
    input  ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready,
    output rec_valid, rec_id, rec_start, rec_end, rec_latency
  );
endinterface

// File: rtl/ap_txn_profiler.sv
// Pairs each accepted ap_start with its completion and buffers
// {id, start, end, latency} records in a first-word-fall-through FIFO.
module ap_txn_profiler #(
  parameter int CNT_W     = 32,
  parameter int ID_W      = 16,
  parameter int MAX_OUT   = 4,
  parameter int OUT_DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  ap_txn_profiler_if.slave             bus,
  output logic [$clog2(MAX_OUT+1)-1:0] pending,
  output logic [1:0]                   state,
  output logic                         ovf_err,
  output logic                         unf_err,
  output logic                         done_flush
);

  localparam int PW  = $clog2(MAX_OUT + 1);
  localparam int QAW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int FAW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int FCW = $clog2(OUT_DEPTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] ts;
  } start_t;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] t_start;
    logic [CNT_W-1:0] t_end;
  } rec_t;

  state_t           st_q, st_d;
  logic [CNT_W-1:0] cyc;
  logic [ID_W-1:0]  id_cnt;

  start_t           q_mem [MAX_OUT];
  logic [QAW-1:0]   q_rd, q_wr;
  logic [PW-1:0]    q_cnt;

  rec_t             f_mem [OUT_DEPTH];
  logic [FAW-1:0]   f_rd, f_wr;
  logic [FCW-1:0]   f_cnt;
  rec_t             head;

  logic active, accept, complete;
  logic q_empty, q_full, f_empty, f_full;
  logic pop, q_pop, q_push, rec_make, f_push, ovf_set, unf_set;
  rec_t rec_new;

  function automatic logic [QAW-1:0] q_inc(input logic [QAW-1:0] p);
    return (p == QAW'(MAX_OUT - 1)) ? '0 : p + QAW'(1);
  endfunction

  function automatic logic [FAW-1:0] f_inc(input logic [FAW-1:0] p);
    return (p == FAW'(OUT_DEPTH - 1)) ? '0 : p + FAW'(1);
  endfunction

  // NOTE: every signal gets a value before any branch, so no path can leave a latch behind.
  always_comb begin
    active   = (st_q == IDLE) || (st_q == RUN);
    accept   = active & bus.ap_start & bus.ap_ready;
    complete = active & bus.ap_done & bus.ap_continue;
    q_empty  = (q_cnt == '0);
    q_full   = (q_cnt == PW'(MAX_OUT));
    f_empty  = (f_cnt == '0);
    f_full   = (f_cnt == FCW'(OUT_DEPTH));
    pop      = !f_empty & bus.rec_ready;
    q_pop    = complete & !q_empty;
    // Accept+complete on an empty queue bypasses it entirely.
    q_push   = accept & !(complete & q_empty) & (!q_full | q_pop);
    rec_make = complete & (!q_empty | accept);
    f_push   = rec_make & (!f_full | pop);
    unf_set  = complete & q_empty & !accept;
    ovf_set  = (accept & q_full & !q_pop) | (rec_make & f_full & !pop);

    rec_new.id      = q_empty ? id_cnt : q_mem[q_rd].id;
    rec_new.t_start = q_empty ? cyc    : q_mem[q_rd].ts;
    rec_new.t_end   = cyc;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:  if (bus.finish) st_d = DRAIN;
             else if (accept) st_d = RUN;
      RUN:   if (bus.finish) st_d = DRAIN;
      DRAIN: if (f_empty && !f_push) st_d = DONE;
      DONE:  st_d = DONE;
    endcase
  end

  // NOTE: buffer storage carries no reset; the counters alone say which slots hold data.
  always_ff @(posedge clock) begin
    if (q_push) q_mem[q_wr] <= '{id: id_cnt, ts: cyc};
    if (f_push) f_mem[f_wr] <= rec_new;
  end

  // NOTE: state updates use non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q    <= IDLE;
      cyc     <= '0;
      id_cnt  <= '0;
      q_rd    <= '0;
      q_wr    <= '0;
      q_cnt   <= '0;
      f_rd    <= '0;
      f_wr    <= '0;
      f_cnt   <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      st_q <= st_d;
      if (st_q != DONE) cyc <= cyc + CNT_W'(1);
      // The id advances even when the entry is dropped, leaving a visible gap.
      if (accept) id_cnt <= id_cnt + ID_W'(1);
      if (q_push) q_wr <= q_inc(q_wr);
      if (q_pop)  q_rd <= q_inc(q_rd);
      q_cnt <= q_cnt + PW'(q_push) - PW'(q_pop);
      if (f_push) f_wr <= f_inc(f_wr);
      if (pop)    f_rd <= f_inc(f_rd);
      f_cnt <= f_cnt + FCW'(f_push) - FCW'(pop);
      if (ovf_set) ovf_err <= 1'b1;
      if (unf_set) unf_err <= 1'b1;
    end
  end

  assign head            = f_mem[f_rd];
  assign bus.rec_valid   = !f_empty;
  assign bus.rec_id      = f_empty ? '0 : head.id;
  assign bus.rec_start   = f_empty ? '0 : head.t_start;
  assign bus.rec_end     = f_empty ? '0 : head.t_end;
  assign bus.rec_latency = f_empty ? '0 : head.t_end - head.t_start;
  assign pending         = q_cnt;
  assign state           = st_q;
  assign done_flush      = (st_q == DONE);

endmodule

// File: tb/tb_ap_txn_profiler.sv
// Drives a 32-bit and a 4-bit-counter profiler with identical stimulus and
// compares both against one queue-based transaction model.
module tb_ap_txn_profiler;

  localparam int MAX_OUT   = 4;
  localparam int OUT_DEPTH = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_start = 1'b0, in_ready = 1'b0, in_done = 1'b0, in_cont = 1'b1;
  logic in_finish = 1'b0, in_rready = 1'b0;

  logic [2:0] pend32, pend4;
  logic [1:0] st32, st4;
  logic       ovf32, ovf4, unf32, unf4, df32, df4;

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  always #5 clock = ~clock;

  ap_txn_profiler_if #(.CNT_W(32), .ID_W(16)) bus32 ();
  ap_txn_profiler_if #(.CNT_W(4),  .ID_W(16)) bus4 ();

  assign bus32.ap_start = in_start;   assign bus4.ap_start = in_start;
  assign bus32.ap_ready = in_ready;   assign bus4.ap_ready = in_ready;
  assign bus32.ap_done = in_done;     assign bus4.ap_done = in_done;
  assign bus32.ap_continue = in_cont; assign bus4.ap_continue = in_cont;
  assign bus32.finish = in_finish;    assign bus4.finish = in_finish;
  assign bus32.rec_ready = in_rready; assign bus4.rec_ready = in_rready;

  ap_txn_profiler #(.CNT_W(32), .ID_W(16), .MAX_OUT(MAX_OUT), .OUT_DEPTH(OUT_DEPTH)) dut32 (
    .clock(clock), .reset(reset), .bus(bus32), .pending(pend32), .state(st32),
    .ovf_err(ovf32), .unf_err(unf32), .done_flush(df32)
  );

  ap_txn_profiler #(.CNT_W(4), .ID_W(16), .MAX_OUT(MAX_OUT), .OUT_DEPTH(OUT_DEPTH)) dut4 (
    .clock(clock), .reset(reset), .bus(bus4), .pending(pend4), .state(st4),
    .ovf_err(ovf4), .unf_err(unf4), .done_flush(df4)
  );

  // Reference model: outstanding starts and buffered records as plain queues.
  typedef struct { logic [15:0] id; logic [31:0] ts; } ent_t;
  typedef struct { logic [15:0] id; logic [31:0] s; logic [31:0] e; } mrec_t;

  ent_t        sq[$];
  mrec_t       rq[$];
  logic [31:0] m_cyc;
  logic [15:0] m_id;
  bit          m_ovf, m_unf;
  int          m_st;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sq.delete();
    rq.delete();
    m_cyc = '0;
    m_id  = '0;
    m_ovf = 0;
    m_unf = 0;
    m_st  = 0;
  endtask

  task automatic model_edge();
    bit    active, acc, cmp, pop, have;
    int    qn, rn, nxt;
    mrec_t r;
    ent_t  e;
    active = (m_st < 2);
    acc    = active && in_start && in_ready;
    cmp    = active && in_done && in_cont;
    qn     = sq.size();
    rn     = rq.size();
    pop    = (rn > 0) && in_rready;
    have   = 0;
    if (cmp) begin
      if (qn > 0) begin
        e = sq.pop_front();
        r.id = e.id; r.s = e.ts; r.e = m_cyc; have = 1;
      end else if (acc) begin
        r.id = m_id; r.s = m_cyc; r.e = m_cyc; have = 1;
      end else begin
        m_unf = 1;
      end
    end
    if (acc) begin
      if (!(cmp && qn == 0)) begin
        if (sq.size() < MAX_OUT) begin
          e.id = m_id; e.ts = m_cyc; sq.push_back(e);
        end else begin
          m_ovf = 1;
        end
      end
      m_id++;
    end
    if (pop) void'(rq.pop_front());
    if (have) begin
      if (rq.size() < OUT_DEPTH) rq.push_back(r);
      else m_ovf = 1;
    end
    nxt = m_st;
    case (m_st)
      0: if (in_finish) nxt = 2; else if (acc) nxt = 1;
      1: if (in_finish) nxt = 2;
      2: if (rn == 0) nxt = 3;
      default: ;
    endcase
    if (m_st != 3) m_cyc++;
    m_st = nxt;
  endtask

  task automatic compare();
    bit    v;
    mrec_t h;
    v = rq.size() > 0;
    check("valid32", bus32.rec_valid, v);
    check("valid4", bus4.rec_valid, v);
    if (v) begin
      h = rq[0];
      check("id32", bus32.rec_id, h.id);
      check("start32", bus32.rec_start, h.s);
      check("end32", bus32.rec_end, h.e);
      check("lat32", bus32.rec_latency, h.e - h.s);
      check("id4", bus4.rec_id, h.id);
      check("start4", bus4.rec_start, h.s & 32'hF);
      check("end4", bus4.rec_end, h.e & 32'hF);
      check("lat4", bus4.rec_latency, (h.e - h.s) & 32'hF);
    end
    check("pend32", pend32, sq.size());
    check("pend4", pend4, sq.size());
    check("state32", st32, m_st);
    check("state4", st4, m_st);
    check("ovf32", ovf32, m_ovf);
    check("ovf4", ovf4, m_ovf);
    check("unf32", unf32, m_unf);
    check("unf4", unf4, m_unf);
    check("df32", df32, m_st == 3);
    check("df4", df4, m_st == 3);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid32"}, bus32.rec_valid, 0); check({tag, "_valid4"}, bus4.rec_valid, 0);
    check({tag, "_id32"}, bus32.rec_id, 0);       check({tag, "_id4"}, bus4.rec_id, 0);
    check({tag, "_start32"}, bus32.rec_start, 0); check({tag, "_start4"}, bus4.rec_start, 0);
    check({tag, "_end32"}, bus32.rec_end, 0);     check({tag, "_end4"}, bus4.rec_end, 0);
    check({tag, "_lat32"}, bus32.rec_latency, 0); check({tag, "_lat4"}, bus4.rec_latency, 0);
    check({tag, "_pend32"}, pend32, 0);           check({tag, "_pend4"}, pend4, 0);
    check({tag, "_state32"}, st32, 0);            check({tag, "_state4"}, st4, 0);
    check({tag, "_ovf32"}, ovf32, 0);             check({tag, "_ovf4"}, ovf4, 0);
    check({tag, "_unf32"}, unf32, 0);             check({tag, "_unf4"}, unf4, 0);
    check({tag, "_df32"}, df32, 0);               check({tag, "_df4"}, df4, 0);
  endtask

  task automatic clear_inputs();
    in_start = 0; in_ready = 0; in_done = 0; in_cont = 1; in_finish = 0; in_rready = 0;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    compare();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    clear_inputs();
    model_reset();
    #1 check_zero("rst");
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Called one time unit after an edge: reset lands between clock edges.
  task automatic async_reset();
    #2 reset = 1'b1;
    model_reset();
    #1 check_zero("async_rst");
    @(negedge clock);
    clear_inputs();
    reset = 1'b0;
  endtask

  task automatic idle_until(input int c);
    int n = 0;
    while (m_cyc != 32'(c) && n < 200) begin
      step();
      n++;
    end
    check("idle_until_reached", m_cyc, 32'(c));
  endtask

  task automatic pulse(input logic s, input logic r, input logic d);
    in_start = s; in_ready = r; in_done = d;
    step();
    in_start = 0; in_ready = 0; in_done = 0;
  endtask

  task automatic run_random(input int cycles, input int p_rready);
    for (int i = 0; i < cycles; i++) begin
      in_start  = ($urandom_range(0, 99) < 40);
      in_ready  = ($urandom_range(0, 99) < 70);
      in_done   = ($urandom_range(0, 99) < 35);
      in_cont   = ($urandom_range(0, 99) < 80);
      in_rready = ($urandom_range(0, 99) < p_rready);
      step();
    end
    clear_inputs();
  endtask

  task automatic drain_to_done();
    int n = 0;
    in_finish = 1; step(); in_finish = 0;
    in_rready = 1;
    while (m_st != 3 && n < 40) begin
      step();
      n++;
    end
    check("drain_reached_done", st32, 3);
    check("drain_done_flush", df32, 1);
    in_rready = 0;
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset = 1'b1;

    phase = "single";
    do_reset();
    idle_until(3);  pulse(1, 1, 0);
    check("p1_state_run", st32, 1);
    idle_until(10); pulse(0, 0, 1);
    check("p1_valid", bus32.rec_valid, 1);
    check("p1_id", bus32.rec_id, 0);
    check("p1_start", bus32.rec_start, 3);
    check("p1_end", bus32.rec_end, 10);
    check("p1_lat", bus32.rec_latency, 7);
    in_rready = 1; step(); in_rready = 0;
    check("p1_empty", bus32.rec_valid, 0);

    phase = "pipelined";
    do_reset();
    for (int k = 0; k < 4; k++) begin
      idle_until(2 + 2 * k);
      pulse(1, 1, 0);
    end
    check("p2_pend_full", pend32, 4);
    check("p2_no_ovf", ovf32, 0);
    idle_until(9); pulse(1, 1, 0);
    check("p2_ovf", ovf32, 1);
    check("p2_pend_still_full", pend32, 4);
    idle_until(12);
    in_done = 1; repeat (4) step(); in_done = 0;
    in_rready = 1;
    for (int k = 0; k < 4; k++) begin
      check("p2_rec_id", bus32.rec_id, k);
      check("p2_rec_lat", bus32.rec_latency, 10 - k);
      step();
    end
    in_rready = 0;
    check("p2_drained", bus32.rec_valid, 0);

    phase = "bypass";
    do_reset();
    idle_until(5); pulse(1, 1, 1);
    check("p3_start", bus32.rec_start, 5);
    check("p3_end", bus32.rec_end, 5);
    check("p3_lat", bus32.rec_latency, 0);
    check("p3_pend", pend32, 0);

    phase = "backpressure";
    do_reset();
    repeat (3) pulse(1, 1, 0);
    repeat (3) pulse(0, 0, 1);
    repeat (3) step();
    check("p4_head_held", bus32.rec_id, 0);
    in_rready = 1;
    for (int k = 0; k < 3; k++) begin
      check("p4_order", bus32.rec_id, k);
      step();
    end
    in_rready = 0;
    check("p4_empty", bus32.rec_valid, 0);

    phase = "underflow_wrap";
    do_reset();
    pulse(0, 0, 1);
    check("p5_unf", unf4, 1);
    check("p5_no_rec", bus4.rec_valid, 0);
    idle_until(14); pulse(1, 1, 0);
    idle_until(18); pulse(0, 0, 1);
    check("p5_start4", bus4.rec_start, 14);
    check("p5_end4", bus4.rec_end, 2);
    check("p5_lat4", bus4.rec_latency, 4);
    check("p5_lat32", bus32.rec_latency, 4);

    phase = "finish";
    do_reset();
    pulse(1, 1, 1);
    pulse(1, 1, 1);
    in_finish = 1; step(); in_finish = 0;
    check("p6_drain", st32, 2);
    step();
    check("p6_still_drain", st4, 2);
    drain_to_done();
    pulse(1, 1, 1);
    check("p6_ignored_pend", pend32, 0);
    check("p6_ignored_rec", bus32.rec_valid, 0);
    async_reset();

    phase = "random";
    do_reset();
    run_random(400, 50);
    drain_to_done();

    phase = "random_stall";
    do_reset();
    run_random(200, 10);
    async_reset();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
